vend_payment_ctrl: RTL and testbench
====================================

Name: vend_payment_ctrl

Overview:
- Stage directly downstream of the keypad collector in the vending machine datapath.
- Consumes the 3-digit selection (concat_press plus the one-cycle check_price strobe) and looks up the item price.
- Accumulates coin credit, issues dispense and change, and drives busy/clear back to the keypad.

Parameters:
- MAX_CREDIT, 200: credit ceiling in 10-cent units; a coin that would exceed it is rejected.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed in COLLECT before auto-refund.
- ERR_HOLD, 4: cycles the error output stays high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- check_price  in  1  one-cycle strobe from the keypad; concat_press is valid in the same cycle only
- concat_press  in  12  [3:0] row digit, [7:4] column digit, [11:8] confirm digit
- coin_valid  in  1  one-cycle coin-inserted pulse
- coin_type  in  2  0=10c, 1=20c, 2=50c, 3=1.00; values 1/2/5/10 units
- cancel  in  1  one-cycle refund request
- busy  out  1  high in every state except IDLE
- clear  out  1  one-cycle pulse that resets the keypad
- price_out  out  8  price of the current selection, in units
- credit_out  out  8  current credit, in units
- dispense  out  1  one-cycle pulse
- item_idx  out  4  dispensed item index; valid with dispense, held afterwards
- change_valid  out  1  one-cycle pulse
- change_amt  out  8  amount returned; valid with change_valid
- coin_reject  out  1  one-cycle pulse; coin returned and credit not updated
- error  out  1  invalid or sold-out selection

Behaviour:
- Reset:
  - All outputs 0, credit 0, state IDLE, timeout counter 0.
  - Reset mid-transaction discards credit with no change pulse.
- Code decode:
  - Valid iff row in 1..4, column in 1..4, and confirm == 4'hE.
  - item index = (row-1)*4 + (col-1).
- States:
  - IDLE: coins accepted. check_price=1 latches concat_press → LOOKUP. busy rises the next cycle.
  - LOOKUP (1 cycle): invalid code → ERROR. Otherwise price_out <= PRICE_TABLE[idx] → COLLECT.
  - COLLECT:
    - Each accepted coin adds its value and zeroes the timeout counter.
    - credit >= price → DISPENSE. The check uses the registered credit, so a completing coin dispenses the cycle after it is added.
    - cancel → REFUND.
    - Counter reaching TIMEOUT_CYCLES-1 → REFUND.
  - DISPENSE (1 cycle): dispense=1, item_idx=idx, credit <= credit - price → CHANGE.
  - CHANGE (1 cycle): if credit != 0, change_valid=1 with change_amt=credit. Then credit <= 0, clear=1 → IDLE.
  - REFUND (1 cycle): same outputs as CHANGE, but no dispense.
  - ERROR:
    - clear=1 on the entry cycle; error=1 for ERR_HOLD cycles → IDLE.
    - Credit is retained.
- Coin rules:
  - In LOOKUP, DISPENSE, CHANGE, REFUND and ERROR: coin_reject=1, credit unchanged.
  - If credit + value > MAX_CREDIT: coin_reject=1 in any state.
- Simultaneous events:
  - Coin and cancel in the same COLLECT cycle: the coin is added, then the whole amount is refunded, so change_amt includes the coin.
  - check_price outside IDLE: ignored.
- Latency: check_price → dispense minimum 3 cycles when credit already covers the price.
- Width rule: credit arithmetic is 9-bit internally; results are never negative because DISPENSE is entered only when credit >= price.

Optional Feature:
- Macro: VEND_STOCK_COUNT_EN.
- Defined:
  - Adds 16 x 4-bit stock counters, reset to STOCK_INIT (package constant, 5).
  - LOOKUP with stock==0 → ERROR (sold out).
  - DISPENSE decrements the stock of idx.
  - Adds a port restock (in, 1): in IDLE, reloads all counters to STOCK_INIT.
- Undefined: stock is unlimited; no restock port, no counters.

Decomposition:
- Package vend_pkg holds:
  - state enum;
  - COIN_VALUE[4] = {1,2,5,10};
  - PRICE_TABLE[16], with entries 0=12, 5=15, 15=25, rest 10;
  - STOCK_INIT;
  - CONFIRM_DIGIT=4'hE.
- Sub-module vend_coin_accum: credit register, saturation check, coin_reject generation, clear and subtract controls.

Test Plan:
- Coins 10,10 (20 units) in IDLE; code {E,1,1} → idx 0 price 12; dispense with idx=0; change_valid with change_amt=8; clear pulse; busy low.
- Code {E,2,2} (idx 5, price 15) with zero credit; coins 5, 5, 5 → dispense on the cycle after the third coin; no change pulse.
- Code {E,5,1} → error high 4 cycles, clear pulse, credit retained, no dispense.
- Credit 7 in COLLECT; cancel with simultaneous coin_type=1 → change_amt=9.
- Credit 195; coin value 10 → coin_reject, credit stays 195. Coin during DISPENSE → coin_reject.
- TIMEOUT_CYCLES=8 with credit 3 → refund of 3 after 8 idle cycles. With VEND_STOCK_COUNT_EN: 5 buys of idx 15, then a 6th → error.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constant tables for the vending payment controller.
// Holds the FSM state enum, coin values, the price table and the keypad code decode helpers.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE,
        S_REFUND,
        S_ERROR
    } state_t;

    localparam logic [3:0] CONFIRM_DIGIT = 4'hE;
    localparam logic [3:0] STOCK_INIT    = 4'd5;

    localparam logic [7:0] COIN_VALUE [4] = '{8'd1, 8'd2, 8'd5, 8'd10};

    localparam logic [7:0] PRICE_TABLE [16] = '{
        8'd12, 8'd10, 8'd10, 8'd10, 8'd10, 8'd15, 8'd10, 8'd10,
        8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd25
    };

    // code layout: [3:0] row, [7:4] column, [11:8] confirm digit
    function automatic logic code_valid(input logic [11:0] code);
        return (code[3:0] >= 4'd1) && (code[3:0] <= 4'd4) &&
               (code[7:4] >= 4'd1) && (code[7:4] <= 4'd4) &&
               (code[11:8] == CONFIRM_DIGIT);
    endfunction

    function automatic logic [3:0] code_idx(input logic [11:0] code);
        logic [3:0] r;
        logic [3:0] c;
        r = code[3:0] - 4'd1;
        c = code[7:4] - 4'd1;
        return {r[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vend_coin_accum.sv
// Credit register for the payment controller: adds accepted coins, subtracts the price,
// clears on change/refund, and flags coins that are refused or would overflow the ceiling.
module vend_coin_accum
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid_i,
    input  logic [1:0] coin_type_i,
    input  logic       accept_en_i,
    input  logic       sub_en_i,
    input  logic [7:0] sub_amt_i,
    input  logic       clr_en_i,
    output logic [7:0] credit_o,
    output logic [8:0] credit_next_o,
    output logic       coin_accept_o,
    output logic       coin_reject_o
);

    logic [8:0] credit_q;
    logic [8:0] credit_d;
    logic [8:0] sum;
    logic       over;
    logic       accept;
    logic       reject_q;

    assign sum    = credit_q + {1'b0, COIN_VALUE[coin_type_i]};
    assign over   = sum > 9'(MAX_CREDIT);
    assign accept = coin_valid_i && accept_en_i && !over;

    // clear and subtract never coincide with an accepted coin: coins are refused in those states
    always_comb begin
        credit_d = credit_q;
        if (clr_en_i) begin
            credit_d = '0;
        end else if (sub_en_i) begin
            credit_d = credit_q - {1'b0, sub_amt_i};
        end else if (accept) begin
            credit_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            credit_q <= credit_d;
            reject_q <= coin_valid_i && !accept;
        end
    end

    assign credit_o      = credit_q[7:0];
    assign credit_next_o = credit_d;
    assign coin_accept_o = accept;
    assign coin_reject_o = reject_q;

endmodule

// File: rtl/vend_payment_ctrl.sv
// Vending payment controller: price lookup, coin credit, dispense, change and refund.
// Optional per-item stock counters and restock port are enabled by VEND_STOCK_COUNT_EN.
module vend_payment_ctrl
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT     = 200,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ERR_HOLD       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        check_price,
    input  logic [11:0] concat_press,
    input  logic        coin_valid,
    input  logic [1:0]  coin_type,
    input  logic        cancel,
`ifdef VEND_STOCK_COUNT_EN
    input  logic        restock,
`endif
    output logic        busy,
    output logic        clear,
    output logic [7:0]  price_out,
    output logic [7:0]  credit_out,
    output logic        dispense,
    output logic [3:0]  item_idx,
    output logic        change_valid,
    output logic [7:0]  change_amt,
    output logic        coin_reject,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = $clog2(ERR_HOLD + 1);

    state_t          state_q;
    logic [11:0]     code_q;
    logic [TW-1:0]   tmo_q;
    logic [EW-1:0]   err_cnt_q;
    logic [7:0]      price_q;
    logic [7:0]      change_amt_q;
    logic [3:0]      item_idx_q;
    logic            clear_q;
    logic            dispense_q;
    logic            change_valid_q;
    logic            error_q;

    logic [7:0]      credit;
    logic [8:0]      credit_next;
    logic            coin_accept;
    logic [3:0]      sel_idx;
    logic            sel_valid;
    logic            sel_in_stock;

    assign sel_idx   = code_idx(code_q);
    assign sel_valid = code_valid(code_q);

    vend_coin_accum #(
        .MAX_CREDIT(MAX_CREDIT)
    ) u_accum (
        .clk           (clk),
        .reset         (reset),
        .coin_valid_i  (coin_valid),
        .coin_type_i   (coin_type),
        .accept_en_i   ((state_q == S_IDLE) || (state_q == S_COLLECT)),
        .sub_en_i      (state_q == S_DISPENSE),
        .sub_amt_i     (price_q),
        .clr_en_i      ((state_q == S_CHANGE) || (state_q == S_REFUND)),
        .credit_o      (credit),
        .credit_next_o (credit_next),
        .coin_accept_o (coin_accept),
        .coin_reject_o (coin_reject)
    );

`ifdef VEND_STOCK_COUNT_EN
    logic [15:0] has_stock;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_stock
            logic [3:0] cnt_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= STOCK_INIT;
                end else if (state_q == S_IDLE && restock) begin
                    cnt_q <= STOCK_INIT;
                end else if (state_q == S_DISPENSE && item_idx_q == 4'(gi)) begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            assign has_stock[gi] = (cnt_q != 4'd0);
        end
    endgenerate

    assign sel_in_stock = has_stock[sel_idx];
`else
    assign sel_in_stock = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            code_q         <= '0;
            tmo_q          <= '0;
            err_cnt_q      <= '0;
            price_q        <= '0;
            change_amt_q   <= '0;
            item_idx_q     <= '0;
            clear_q        <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            clear_q        <= 1'b0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (check_price) begin
                        code_q  <= concat_press;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    tmo_q <= '0;
                    if (!sel_valid || !sel_in_stock) begin
                        state_q   <= S_ERROR;
                        clear_q   <= 1'b1;
                        error_q   <= 1'b1;
                        err_cnt_q <= EW'(ERR_HOLD - 1);
                    end else begin
                        price_q <= PRICE_TABLE[sel_idx];
                        state_q <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // credit_next already includes a coin arriving with cancel, so it is refunded too
                    if (credit >= price_q) begin
                        state_q    <= S_DISPENSE;
                        dispense_q <= 1'b1;
                        item_idx_q <= sel_idx;
                    end else if (cancel ||
                                 (tmo_q == TW'(TIMEOUT_CYCLES - 1) && !coin_accept)) begin
                        state_q        <= S_REFUND;
                        clear_q        <= 1'b1;
                        change_valid_q <= (credit_next != 9'd0);
                        change_amt_q   <= credit_next[7:0];
                    end else if (coin_accept) begin
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_DISPENSE: begin
                    state_q        <= S_CHANGE;
                    clear_q        <= 1'b1;
                    change_valid_q <= (credit_next != 9'd0);
                    change_amt_q   <= credit_next[7:0];
                end
                S_CHANGE, S_REFUND: begin
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    if (err_cnt_q == '0) begin
                        error_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        err_cnt_q <= err_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign clear        = clear_q;
    assign price_out    = price_q;
    assign credit_out   = credit;
    assign dispense     = dispense_q;
    assign item_idx     = item_idx_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign error        = error_q;

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Directed testbench for vend_payment_ctrl with a shortened timeout of 8 cycles.
// Covers purchase with change, exact payment, bad code, cancel, saturation, timeout and reset.
module tb_vend_payment_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        check_price;
    logic [11:0] concat_press;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic        cancel;
`ifdef VEND_STOCK_COUNT_EN
    logic        restock;
`endif
    logic        busy;
    logic        clear;
    logic [7:0]  price_out;
    logic [7:0]  credit_out;
    logic        dispense;
    logic [3:0]  item_idx;
    logic        change_valid;
    logic [7:0]  change_amt;
    logic        coin_reject;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_payment_ctrl #(
        .MAX_CREDIT    (200),
        .TIMEOUT_CYCLES(8),
        .ERR_HOLD      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .check_price  (check_price),
        .concat_press (concat_press),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
`ifdef VEND_STOCK_COUNT_EN
        .restock      (restock),
`endif
        .busy         (busy),
        .clear        (clear),
        .price_out    (price_out),
        .credit_out   (credit_out),
        .dispense     (dispense),
        .item_idx     (item_idx),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .error        (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic press(input logic [11:0] code);
        check_price  = 1'b1;
        concat_press = code;
        tick();
        check_price  = 1'b0;
        concat_press = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, clear, price_out, credit_out, dispense, item_idx, change_valid,
             change_amt, coin_reject, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0d clear=%0d price=%0d credit=%0d disp=%0d idx=%0d cv=%0d amt=%0d rej=%0d err=%0d expected all 0",
                     busy, clear, price_out, credit_out, dispense, item_idx, change_valid, change_amt, coin_reject, error);
        end
        $display("txn reset: outputs checked");
    endtask

    task automatic test_buy_with_change();
        put_coin(2'd3);
        put_coin(2'd3);
        checks++;
        if (credit_out !== 8'd20) begin
            errors++;
            $display("FAIL buy_credit: got %0d expected 20", credit_out);
        end
        press(12'hE11);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL buy_busy: got %0d expected 1", busy);
        end
        tick();
        checks++;
        if (price_out !== 8'd12) begin
            errors++;
            $display("FAIL buy_price: got %0d expected 12", price_out);
        end
        tick();
        checks++;
        if ({dispense, item_idx} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL buy_dispense: got disp=%0d idx=%0d expected disp=1 idx=0", dispense, item_idx);
        end
        tick();
        checks++;
        if ({dispense, change_valid, change_amt, clear} !== {1'b0, 1'b1, 8'd8, 1'b1}) begin
            errors++;
            $display("FAIL buy_change: got disp=%0d cv=%0d amt=%0d clear=%0d expected disp=0 cv=1 amt=8 clear=1",
                     dispense, change_valid, change_amt, clear);
        end
        tick();
        checks++;
        if ({change_valid, clear, busy, credit_out} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL buy_idle: got cv=%0d clear=%0d busy=%0d credit=%0d expected 0 0 0 0",
                     change_valid, clear, busy, credit_out);
        end
        $display("txn buy_with_change: code E11 credit 20");
    endtask

    task automatic test_exact_pay();
        press(12'hE22);
        tick();
        checks++;
        if ({price_out, credit_out} !== {8'd15, 8'd0}) begin
            errors++;
            $display("FAIL exact_price: got price=%0d credit=%0d expected 15 0", price_out, credit_out);
        end
        put_coin(2'd2);
        put_coin(2'd2);
        put_coin(2'd2);
        checks++;
        if ({dispense, credit_out} !== {1'b0, 8'd15}) begin
            errors++;
            $display("FAIL exact_third_coin: got disp=%0d credit=%0d expected 0 15", dispense, credit_out);
        end
        tick();
        checks++;
        if ({dispense, item_idx} !== {1'b1, 4'd5}) begin
            errors++;
            $display("FAIL exact_dispense: got disp=%0d idx=%0d expected 1 5", dispense, item_idx);
        end
        tick();
        checks++;
        if ({change_valid, clear} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL exact_nochange: got cv=%0d clear=%0d expected 0 1", change_valid, clear);
        end
        tick();
        checks++;
        if ({busy, credit_out} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL exact_idle: got busy=%0d credit=%0d expected 0 0", busy, credit_out);
        end
        $display("txn exact_pay: code E22 coins 5,5,5");
    endtask

    task automatic test_invalid_code();
        int   n;
        logic saw_disp;
        put_coin(2'd0);
        press(12'hE51);
        tick();
        checks++;
        if ({error, clear} !== {1'b1, 1'b1}) begin
            errors++;
            $display("FAIL bad_entry: got err=%0d clear=%0d expected 1 1", error, clear);
        end
        n = 1;
        saw_disp = dispense;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw_disp = saw_disp | dispense;
            if (i == 0) begin
                checks++;
                if (clear !== 1'b0) begin
                    errors++;
                    $display("FAIL bad_clear_pulse: got %0d expected 0", clear);
                end
            end
            if (error) n++;
            else break;
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL bad_err_hold: got %0d cycles expected 4", n);
        end
        checks++;
        if ({busy, credit_out, saw_disp} !== {1'b0, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL bad_after: got busy=%0d credit=%0d disp=%0d expected 0 1 0", busy, credit_out, saw_disp);
        end
        $display("txn invalid_code: code E51");
    endtask

    task automatic test_cancel_with_coin();
        put_coin(2'd2);
        put_coin(2'd0);
        checks++;
        if (credit_out !== 8'd7) begin
            errors++;
            $display("FAIL cancel_credit: got %0d expected 7", credit_out);
        end
        press(12'hE34);
        tick();
        checks++;
        if (price_out !== 8'd10) begin
            errors++;
            $display("FAIL cancel_price: got %0d expected 10", price_out);
        end
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_type  = 2'd1;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        checks++;
        if ({change_valid, change_amt, clear, dispense} !== {1'b1, 8'd9, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL cancel_refund: got cv=%0d amt=%0d clear=%0d disp=%0d expected 1 9 1 0",
                     change_valid, change_amt, clear, dispense);
        end
        tick();
        checks++;
        if ({busy, credit_out} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL cancel_idle: got busy=%0d credit=%0d expected 0 0", busy, credit_out);
        end
        $display("txn cancel_with_coin: credit 7 plus coin 2");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) put_coin(2'd3);
        put_coin(2'd2);
        checks++;
        if (credit_out !== 8'd195) begin
            errors++;
            $display("FAIL sat_credit: got %0d expected 195", credit_out);
        end
        put_coin(2'd3);
        checks++;
        if ({coin_reject, credit_out} !== {1'b1, 8'd195}) begin
            errors++;
            $display("FAIL sat_reject: got rej=%0d credit=%0d expected 1 195", coin_reject, credit_out);
        end
        put_coin(2'd2);
        checks++;
        if ({coin_reject, credit_out} !== {1'b0, 8'd200}) begin
            errors++;
            $display("FAIL sat_at_max: got rej=%0d credit=%0d expected 0 200", coin_reject, credit_out);
        end
        put_coin(2'd0);
        checks++;
        if ({coin_reject, credit_out} !== {1'b1, 8'd200}) begin
            errors++;
            $display("FAIL sat_over_max: got rej=%0d credit=%0d expected 1 200", coin_reject, credit_out);
        end
        press(12'hE11);
        tick();
        tick();
        checks++;
        if (dispense !== 1'b1) begin
            errors++;
            $display("FAIL sat_dispense: got %0d expected 1", dispense);
        end
        coin_valid = 1'b1;
        coin_type  = 2'd0;
        tick();
        coin_valid = 1'b0;
        checks++;
        if ({coin_reject, change_valid, change_amt} !== {1'b1, 1'b1, 8'd188}) begin
            errors++;
            $display("FAIL sat_disp_coin: got rej=%0d cv=%0d amt=%0d expected 1 1 188",
                     coin_reject, change_valid, change_amt);
        end
        tick();
        checks++;
        if ({busy, credit_out} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL sat_idle: got busy=%0d credit=%0d expected 0 0", busy, credit_out);
        end
        $display("txn saturation: credit 195 to 200, coin during dispense");
    endtask

    task automatic test_timeout();
        int n;
        put_coin(2'd0);
        put_coin(2'd1);
        press(12'hE12);
        tick();
        n = 0;
        check_price  = 1'b1;
        concat_press = 12'hE11;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_price  = 1'b0;
            concat_press = '0;
            n++;
            if (change_valid) break;
        end
        checks++;
        if ({n, change_valid, change_amt, price_out} !== {32'd8, 1'b1, 8'd3, 8'd10}) begin
            errors++;
            $display("FAIL timeout_refund: got cycles=%0d cv=%0d amt=%0d price=%0d expected 8 1 3 10",
                     n, change_valid, change_amt, price_out);
        end
        tick();
        checks++;
        if ({busy, credit_out} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%0d credit=%0d expected 0 0", busy, credit_out);
        end
        $display("txn timeout: credit 3 refunded, %0d cycles", n);
    endtask

    task automatic test_reset_mid();
        put_coin(2'd3);
        press(12'hE44);
        tick();
        checks++;
        if ({busy, price_out, credit_out} !== {1'b1, 8'd25, 8'd10}) begin
            errors++;
            $display("FAIL midrst_before: got busy=%0d price=%0d credit=%0d expected 1 25 10",
                     busy, price_out, credit_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, price_out, credit_out, change_valid} !== '0) begin
            errors++;
            $display("FAIL midrst_after: got busy=%0d price=%0d credit=%0d cv=%0d expected 0 0 0 0",
                     busy, price_out, credit_out, change_valid);
        end
        tick();
        checks++;
        if (change_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nochange: got %0d expected 0", change_valid);
        end
        $display("txn reset_mid: credit discarded");
    endtask

`ifdef VEND_STOCK_COUNT_EN
    task automatic test_stock();
        for (int k = 0; k < 5; k++) begin
            put_coin(2'd3);
            put_coin(2'd3);
            put_coin(2'd2);
            press(12'hE44);
            tick();
            tick();
            checks++;
            if ({dispense, item_idx} !== {1'b1, 4'd15}) begin
                errors++;
                $display("FAIL stock_buy%0d: got disp=%0d idx=%0d expected 1 15", k, dispense, item_idx);
            end
            tick();
            tick();
        end
        put_coin(2'd3);
        put_coin(2'd3);
        put_coin(2'd2);
        press(12'hE44);
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL stock_soldout: got %0d expected 1", error);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({busy, credit_out} !== {1'b0, 8'd25}) begin
            errors++;
            $display("FAIL stock_retained: got busy=%0d credit=%0d expected 0 25", busy, credit_out);
        end
        restock = 1'b1;
        tick();
        restock = 1'b0;
        press(12'hE44);
        tick();
        tick();
        checks++;
        if (dispense !== 1'b1) begin
            errors++;
            $display("FAIL stock_restocked: got %0d expected 1", dispense);
        end
        tick();
        tick();
        $display("txn stock: 5 buys, sold out, restock");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        check_price  = 1'b0;
        concat_press = '0;
        coin_valid   = 1'b0;
        coin_type    = '0;
        cancel       = 1'b0;
`ifdef VEND_STOCK_COUNT_EN
        restock      = 1'b0;
`endif
        test_reset();
        test_buy_with_change();
        test_exact_pay();
        test_invalid_code();
        test_cancel_with_coin();
        test_saturation();
        test_timeout();
        test_reset_mid();
`ifdef VEND_STOCK_COUNT_EN
        test_stock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
